// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the single write port of the 16x16 register file among up to three
// writeback requesters using round-robin arbitration with valid/ready
// handshakes. A one-entry registered output stage drives the write port. A
// clear sequencer zeroes all 16 registers on command. With ZERO_R0=1,
// requester writes to register 0 are accepted but dropped.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   req_valid  per-requester write request            [NUM_REQ]
//   req_ready  per-requester accept (one-hot grant)   [NUM_REQ]
//   req_addr   packed target registers, 4 bits each   [4*NUM_REQ]
//   req_data   packed write data, 16 bits each        [16*NUM_REQ]
//   rf_hold    stall, blocks commit of the output stage
//   clr_start  start a full-file clear (honoured in IDLE only)
//   clr_busy   clear sequence in progress
//   clr_done   one-cycle pulse as the last clear write commits
//   rf_we      register file write enable
//   rf_waddr   register file write address
//   rf_wdata   register file write data
//   rf_wsrc    source of the write: requester index, 3 = clear sequencer
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ZERO_R0 = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [4*NUM_REQ-1:0]    req_addr,
  input  logic [16*NUM_REQ-1:0]   req_data,
  input  logic                    rf_hold,
  input  logic                    clr_start,
  output logic                    clr_busy,
  output logic                    clr_done,
  output logic                    rf_we,
  output logic [3:0]              rf_waddr,
  output logic [15:0]             rf_wdata,
  output logic [1:0]              rf_wsrc
);

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  localparam logic [1:0] SRC_CLR = 2'd3;
  localparam logic [1:0] RR_INIT = 2'(NUM_REQ - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [1:0]        rr;
  logic              busy_q;

  // output stage registers
  logic              vld_p1;
  logic [ADDR_W-1:0] waddr_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic [1:0]        wsrc_p1;

  logic              can_load;
  logic              arb_en;
  logic [NUM_REQ-1:0] gnt;
  logic              gnt_any;
  logic [1:0]        gnt_idx;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;
  logic              drop_r0;

  assign rf_we    = vld_p1 & ~rf_hold;
  assign rf_waddr = waddr_p1;
  assign rf_wdata = wdata_p1;
  assign rf_wsrc  = wsrc_p1;

  assign can_load = ~vld_p1 | rf_we;
  // clr_start wins over pending requests in the cycle it is seen
  assign arb_en   = ~reset & (state == IDLE) & ~clr_start & can_load;

  // Round-robin: first pass covers requesters above the last winner, second
  // pass wraps around to index 0 up to and including the last winner.
  always_comb begin
    gnt      = '0;
    gnt_any  = 1'b0;
    gnt_idx  = 2'd0;
    gnt_addr = '0;
    gnt_data = '0;
    if (arb_en) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!gnt_any && req_valid[j] && (j > int'(rr))) begin
          gnt[j]   = 1'b1;
          gnt_any  = 1'b1;
          gnt_idx  = 2'(j);
          gnt_addr = req_addr[4*j +: 4];
          gnt_data = req_data[16*j +: 16];
        end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!gnt_any && req_valid[j] && (j <= int'(rr))) begin
          gnt[j]   = 1'b1;
          gnt_any  = 1'b1;
          gnt_idx  = 2'(j);
          gnt_addr = req_addr[4*j +: 4];
          gnt_data = req_data[16*j +: 16];
        end
      end
    end
  end

  assign req_ready = gnt;

  // Accepted write to R0 completes its handshake but never reaches the stage.
  assign drop_r0  = (ZERO_R0 != 0) && (gnt_addr == 4'd0);

  assign clr_busy = busy_q;
  // The final clear write is the only commit that happens while in FLUSH.
  assign clr_done = (state == FLUSH) & rf_we;

  // ---- stage p1: arbitration / clear sequencer -> output stage ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rr       <= RR_INIT;
      busy_q   <= 1'b0;
      vld_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
      wsrc_p1  <= '0;
    end else begin
      if (rf_we) begin
        vld_p1 <= 1'b0;
      end

      if (gnt_any) begin
        rr <= gnt_idx;
      end

      case (state)
        IDLE: begin
          if (clr_start) begin
            state  <= DRAIN;
            busy_q <= 1'b1;
          end else if (gnt_any && !drop_r0) begin
            vld_p1   <= 1'b1;
            waddr_p1 <= gnt_addr;
            wdata_p1 <= gnt_data;
            wsrc_p1  <= gnt_idx;
          end
        end

        DRAIN: begin
          // waits for any in-flight requester write to leave the stage
          if (can_load) begin
            vld_p1   <= 1'b1;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
            wsrc_p1  <= SRC_CLR;
            cnt      <= 4'd1;
            state    <= CLEAR;
          end
        end

        CLEAR: begin
          // cnt only advances on a load, so rf_hold never skips an address
          if (can_load) begin
            vld_p1   <= 1'b1;
            waddr_p1 <= cnt;
            wdata_p1 <= '0;
            wsrc_p1  <= SRC_CLR;
            cnt      <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              state <= FLUSH;
            end
          end
        end

        FLUSH: begin
          if (rf_we) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Drives two instances sharing all inputs: dut (ZERO_R0=0) and dut_z
// (ZERO_R0=1). A table of per-cycle vectors covers reset state, round-robin
// ordering and rf_hold stalls; hand-written sequences cover the clear
// sequencer, reset during a clear and R0 protection.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic        rf_hold;
  logic        clr_start;
  logic [3:0]  a0, a1, a2;
  logic [15:0] d0, d1, d2;
  logic [11:0] req_addr;
  logic [47:0] req_data;

  logic [2:0]  rdy_n, rdy_z;
  logic        busy_n, busy_z, done_n, done_z, we_n, we_z;
  logic [3:0]  wa_n, wa_z;
  logic [15:0] wd_n, wd_z;
  logic [1:0]  ws_n, ws_z;

  int checks = 0;
  int errors = 0;

  assign req_addr = {a2, a1, a0};
  assign req_data = {d2, d1, d0};

  always #5 clk = ~clk;

  regfile_write_arbiter #(.NUM_REQ(3), .ZERO_R0(0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy_n),
    .req_addr(req_addr), .req_data(req_data), .rf_hold(rf_hold),
    .clr_start(clr_start), .clr_busy(busy_n), .clr_done(done_n),
    .rf_we(we_n), .rf_waddr(wa_n), .rf_wdata(wd_n), .rf_wsrc(ws_n)
  );

  regfile_write_arbiter #(.NUM_REQ(3), .ZERO_R0(1)) dut_z (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy_z),
    .req_addr(req_addr), .req_data(req_data), .rf_hold(rf_hold),
    .clr_start(clr_start), .clr_busy(busy_z), .clr_done(done_z),
    .rf_we(we_z), .rf_waddr(wa_z), .rf_wdata(wd_z), .rf_wsrc(ws_z)
  );

  typedef struct {
    logic [2:0]  valid;
    logic        hold;
    logic [2:0]  ready;
    logic        we;
    logic [3:0]  addr;
    logic [15:0] data;
    logic [1:0]  src;
    logic        chk;   // compare stage registers even when we=0
  } vec_t;

  vec_t tbl[15];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_row(input string tag, input int i, input logic [2:0] rdy,
                         input logic we, input logic [3:0] wa, input logic [15:0] wd,
                         input logic [1:0] ws, input logic busy, input logic done);
    string nm;
    nm = $sformatf("%s_row%0d", tag, i);
    cmp({nm, "_ready"}, 32'(rdy), 32'(tbl[i].ready));
    cmp({nm, "_we"}, 32'(we), 32'(tbl[i].we));
    cmp({nm, "_busy"}, 32'(busy), 32'd0);
    cmp({nm, "_done"}, 32'(done), 32'd0);
    if (tbl[i].we || tbl[i].chk) begin
      cmp({nm, "_addr"}, 32'(wa), 32'(tbl[i].addr));
      cmp({nm, "_data"}, 32'(wd), 32'(tbl[i].data));
      cmp({nm, "_src"}, 32'(ws), 32'(tbl[i].src));
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e, hc, n;
    logic hold;

    tbl[0]  = '{3'b000, 1'b0, 3'b000, 1'b0, 4'd0,  16'h0000, 2'd0, 1'b1};
    tbl[1]  = '{3'b001, 1'b0, 3'b001, 1'b0, 4'd0,  16'h0000, 2'd0, 1'b0};
    tbl[2]  = '{3'b000, 1'b0, 3'b000, 1'b1, 4'd5,  16'hBEEF, 2'd0, 1'b1};
    tbl[3]  = '{3'b111, 1'b0, 3'b010, 1'b0, 4'd0,  16'h0000, 2'd0, 1'b0};
    tbl[4]  = '{3'b111, 1'b0, 3'b100, 1'b1, 4'd9,  16'h1111, 2'd1, 1'b1};
    tbl[5]  = '{3'b111, 1'b0, 3'b001, 1'b1, 4'd12, 16'h2222, 2'd2, 1'b1};
    tbl[6]  = '{3'b111, 1'b0, 3'b010, 1'b1, 4'd5,  16'hBEEF, 2'd0, 1'b1};
    tbl[7]  = '{3'b111, 1'b0, 3'b100, 1'b1, 4'd9,  16'h1111, 2'd1, 1'b1};
    tbl[8]  = '{3'b111, 1'b0, 3'b001, 1'b1, 4'd12, 16'h2222, 2'd2, 1'b1};
    tbl[9]  = '{3'b111, 1'b1, 3'b000, 1'b0, 4'd5,  16'hBEEF, 2'd0, 1'b1};
    tbl[10] = '{3'b111, 1'b1, 3'b000, 1'b0, 4'd5,  16'hBEEF, 2'd0, 1'b1};
    tbl[11] = '{3'b111, 1'b1, 3'b000, 1'b0, 4'd5,  16'hBEEF, 2'd0, 1'b1};
    tbl[12] = '{3'b111, 1'b0, 3'b010, 1'b1, 4'd5,  16'hBEEF, 2'd0, 1'b1};
    tbl[13] = '{3'b000, 1'b0, 3'b000, 1'b1, 4'd9,  16'h1111, 2'd1, 1'b1};
    tbl[14] = '{3'b000, 1'b0, 3'b000, 1'b0, 4'd9,  16'h1111, 2'd1, 1'b1};

    a0 = 4'd5;  d0 = 16'hBEEF;
    a1 = 4'd9;  d1 = 16'h1111;
    a2 = 4'd12; d2 = 16'h2222;
    reset = 1'b1; rf_hold = 1'b0; clr_start = 1'b0;
    req_valid = 3'b111;

    // reset held: outputs at reset values, no ready
    #2;
    cmp("rst_ready", 32'(rdy_n), 32'd0);
    cmp("rst_ready_z", 32'(rdy_z), 32'd0);
    cmp("rst_we", 32'(we_n), 32'd0);
    cmp("rst_busy", 32'(busy_n), 32'd0);
    cmp("rst_waddr", 32'(wa_n), 32'd0);
    req_valid = 3'b000;
    @(negedge clk);
    reset = 1'b0;
    drive_edge();

    // table-driven vectors, one row per cycle
    for (int i = 0; i < 15; i++) begin
      req_valid = tbl[i].valid;
      rf_hold   = tbl[i].hold;
      @(negedge clk);
      chk_row("n", i, rdy_n, we_n, wa_n, wd_n, ws_n, busy_n, done_n);
      chk_row("z", i, rdy_z, we_z, wa_z, wd_z, ws_z, busy_z, done_z);
      drive_edge();
    end
    rf_hold = 1'b0;

    // clear sequence with a req2 write in flight
    req_valid = 3'b100;
    @(negedge clk);
    cmp("clr_pre_ready", 32'(rdy_n), 32'b100);
    drive_edge();
    req_valid = 3'b001;
    clr_start = 1'b1;
    @(negedge clk);
    cmp("clr_start_ready", 32'(rdy_n), 32'd0);
    cmp("clr_start_we", 32'(we_n), 32'd1);
    cmp("clr_start_addr", 32'(wa_n), 32'd12);
    cmp("clr_start_src", 32'(ws_n), 32'd2);
    cmp("clr_start_busy", 32'(busy_n), 32'd0);
    drive_edge();
    clr_start = 1'b0;
    @(negedge clk);
    cmp("clr_drain_we", 32'(we_n), 32'd0);
    cmp("clr_drain_busy", 32'(busy_n), 32'd1);
    cmp("clr_drain_ready", 32'(rdy_n), 32'd0);
    drive_edge();

    e = 0; hc = 0; n = 0;
    while (e < 16 && n < 40) begin
      hold = (e == 4 && hc < 2);
      if (hold) hc++;
      rf_hold   = hold;
      clr_start = (n == 5);
      @(negedge clk);
      cmp($sformatf("clr%0d_we", e), 32'(we_n), 32'(!hold));
      cmp($sformatf("clr%0d_we_z", e), 32'(we_z), 32'(!hold));
      cmp($sformatf("clr%0d_addr", e), 32'(wa_n), 32'(e));
      cmp($sformatf("clr%0d_addr_z", e), 32'(wa_z), 32'(e));
      cmp($sformatf("clr%0d_data", e), 32'(wd_n), 32'd0);
      cmp($sformatf("clr%0d_src", e), 32'(ws_n), 32'd3);
      cmp($sformatf("clr%0d_done", e), 32'(done_n), 32'(!hold && e == 15));
      cmp($sformatf("clr%0d_busy", e), 32'(busy_n), 32'd1);
      cmp($sformatf("clr%0d_ready", e), 32'(rdy_n), 32'd0);
      if (!hold) e++;
      n++;
      drive_edge();
    end
    if (e != 16) begin
      errors++;
      $display("FAIL clr_timeout reached_addr=%0d required=16", e);
    end
    rf_hold = 1'b0;
    clr_start = 1'b0;

    @(negedge clk);
    cmp("post_clr_busy", 32'(busy_n), 32'd0);
    cmp("post_clr_done", 32'(done_n), 32'd0);
    cmp("post_clr_we", 32'(we_n), 32'd0);
    cmp("post_clr_ready", 32'(rdy_n), 32'b001);
    drive_edge();
    req_valid = 3'b000;
    @(negedge clk);
    cmp("post_clr2_busy", 32'(busy_n), 32'd0);
    cmp("post_clr2_we", 32'(we_n), 32'd1);
    cmp("post_clr2_addr", 32'(wa_n), 32'd5);
    cmp("post_clr2_src", 32'(ws_n), 32'd0);
    drive_edge();

    // reset asserted mid-clear with cnt=7 (stage holding address 6)
    clr_start = 1'b1;
    drive_edge();
    clr_start = 1'b0;
    req_valid = 3'b111;
    n = 0;
    while (!(we_n && wa_n == 4'd6 && ws_n == 2'd3) && n < 30) begin
      drive_edge();
      n++;
    end
    cmp("rstclr_reached_addr6", 32'(n < 30), 32'd1);
    reset = 1'b1;
    #1;
    cmp("rstclr_we", 32'(we_n), 32'd0);
    cmp("rstclr_busy", 32'(busy_n), 32'd0);
    cmp("rstclr_done", 32'(done_n), 32'd0);
    cmp("rstclr_ready", 32'(rdy_n), 32'd0);
    #2;
    reset = 1'b0;
    @(negedge clk);
    cmp("rstrel_ready", 32'(rdy_n), 32'b001);
    cmp("rstrel_ready_z", 32'(rdy_z), 32'b001);
    cmp("rstrel_we", 32'(we_n), 32'd0);
    cmp("rstrel_busy", 32'(busy_n), 32'd0);
    cmp("rstrel_done", 32'(done_n), 32'd0);
    drive_edge();

    // R0 protection: req1 writes address 0
    a1 = 4'd0; d1 = 16'h1234;
    req_valid = 3'b010;
    @(negedge clk);
    cmp("r0_ready", 32'(rdy_n), 32'b010);
    cmp("r0_ready_z", 32'(rdy_z), 32'b010);
    drive_edge();
    req_valid = 3'b000;
    @(negedge clk);
    cmp("r0_we", 32'(we_n), 32'd1);
    cmp("r0_addr", 32'(wa_n), 32'd0);
    cmp("r0_data", 32'(wd_n), 32'h1234);
    cmp("r0_src", 32'(ws_n), 32'd1);
    cmp("r0_we_z", 32'(we_z), 32'd0);
    drive_edge();
    req_valid = 3'b111;
    @(negedge clk);
    cmp("r0_rr_ready", 32'(rdy_n), 32'b100);
    cmp("r0_rr_ready_z", 32'(rdy_z), 32'b100);
    cmp("r0_rr_we_z", 32'(we_z), 32'd0);
    drive_edge();
    req_valid = 3'b000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single write port of the 16x16 register file among up to three writeback requesters (e.g. ALU, load unit, debug) using round-robin arbitration with valid/ready handshakes. A one-entry registered output stage drives the register file write port. A built-in clear sequencer zeroes all 16 registers on command. The optional R0 protection drops writes to register 0.

Parameters:
NUM_REQ, 3, number of requesters (legal 1..3)
ZERO_R0, 0, 1 = accepted writes to address 0 are discarded (R0 hardwired zero)

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester write request
req_ready  output  NUM_REQ  per-requester accept; handshake = valid & ready
req_addr  input  4*NUM_REQ  packed target register, requester i at [4i+3:4i]
req_data  input  16*NUM_REQ  packed write data, requester i at [16i+15:16i]
rf_hold  input  1  stall; blocks commit of the output stage
clr_start  input  1  request full-file clear (sampled in IDLE only)
clr_busy  output  1  clear sequence in progress
clr_done  output  1  one-cycle pulse when final clear write commits
rf_we  output  1  register file write enable
rf_waddr  output  4  register file write address
rf_wdata  output  16  register file write data
rf_wsrc  output  2  source of current write: requester index, 3 = clear sequencer

Behaviour:
- Reset (async): stage valid s_v=0, rf_we=0, rf_waddr=0, rf_wdata=0, rf_wsrc=0, FSM=IDLE, clr_busy=0, clr_done=0, rr pointer=NUM_REQ-1 (req0 wins first). req_ready forced 0 while reset high.
- Output stage: rf_we = s_v & ~rf_hold (combinational). rf_waddr/rf_wdata/rf_wsrc are the stage registers. Stage drains when rf_we=1. Stage can load = ~s_v | rf_we.
- Arbitration (IDLE only, clr_start=0, can load): grant the first valid requester searching from rr+1 upward with wrap. req_ready is one-hot to the granted requester, otherwise 0. rr updates to the winner only on a handshake.
- Latency: handshake in cycle N -> rf_we=1 in cycle N+1 unless rf_hold. Throughput is one write per cycle.
- ZERO_R0=1 with addr 0: the handshake completes and rr updates, but the stage is not loaded. s_v becomes 0 if the stage drained this cycle.
- FSM states:
  - IDLE: clr_start=1 -> DRAIN; no grant that cycle (clr_start has priority over requests); clr_busy=1 from next cycle.
  - DRAIN: no grants. When can_load, load stage with (addr 0, data 0, src 3), set cnt=1 -> CLEAR.
  - CLEAR: no grants. Each cycle can_load, load (cnt, 0, src 3) and increment cnt. After loading addr 15 -> FLUSH.
  - FLUSH: no grants. When rf_we=1 (addr 15 commits), pulse clr_done, clr_busy=0 next cycle -> IDLE.
- Clear writes address 0 even when ZERO_R0=1.
- rf_hold during clear stalls the sequence without skipping or repeating addresses.
- clr_start outside IDLE is ignored.
- clr_busy is high from the cycle after clr_start acceptance through the clr_done cycle inclusive.
- req_valid may drop without a handshake; there are no stickiness requirements.
- Reset mid-operation: all state returns to reset values immediately; the pending stage write is lost.

Test Plan:
- Reset release, req0 valid addr 5 data 0xBEEF -> req_ready[0]=1 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xBEEF, rf_wsrc=0.
- All three requesters held valid with distinct addr/data, rf_hold=0 -> grants 0,1,2,0,1,2 on consecutive cycles; rf_we continuously 1 with matching addr/data/src.
- Stage full, rf_hold=1 for 3 cycles -> rf_we=0 and req_ready=0 throughout, stage values stable; hold released -> write commits that cycle and the next requester is granted the same cycle.
- ZERO_R0=1: req1 addr 0 data 0x1234 -> ready=1, no rf_we next cycle; same stimulus with ZERO_R0=0 -> rf_we=1, addr 0, data 0x1234.
- Stage holding req2 write, req0 valid, clr_start pulse -> req2 write commits first, then 16 consecutive writes addr 0..15 data 0 src 3; clr_done pulses with the addr 15 write; req_ready=0 throughout; req0 granted the cycle after clr_done.
- Reset asserted during CLEAR at cnt=7 -> rf_we=0 immediately, clr_busy=0, no clr_done; after release, req0 is granted first.
